mole_controller: RTL and testbench
==================================

# mole_controller

Per-round mole generator and hit judge for the whack-a-mole game. While enabled by the game control FSM, it lights one of eight mole LEDs in pseudo-random order for a difficulty-dependent window. It judges player button presses against the lit mole and issues single-cycle `hit_pulse` / `timeout_pulse` events, which the game control FSM and the score counter consume.

## Interface
- `TICK_CYCLES`, default 100000: clk cycles per 1 ms tick (100 MHz clk).
- `GAP_MS`, default 250: blank interval between moles, in ms.
- `UP_MS_0`, default 1500: mole-up window at difficulty 0, in ms.
- `UP_MS_1`, default 1000: mole-up window at difficulty 1, in ms.
- `UP_MS_2`, default 700: mole-up window at difficulty 2, in ms.
- `UP_MS_3`, default 450: mole-up window at difficulty 3, in ms.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request, driven from `enable_mole_ctrl`.
- `difficulty_level` in 2: selects the up window; sampled on entry to UP.
- `btn_hit` in 8: debounced, level-high player buttons, one per mole.
- `mole_leds` out 8: one-hot lit mole; all zero when no mole is up.
- `mole_index` out 3: index of the current or last mole.
- `hit_pulse` out 1: one-cycle strobe for a correct hit.
- `timeout_pulse` out 1: one-cycle strobe when a mole expires unhit.

## Operation
- **States:**
  - IDLE: outputs quiet.
  - GAP: all moles down; waits `GAP_MS`.
  - UP: one mole lit; waits for a hit or for the up window to expire.
- **Transitions:**
  - IDLE→GAP when `enable`=1.
  - GAP→UP when the ms counter reaches `GAP_MS`.
  - UP→GAP on a correct hit, or when the ms counter reaches `UP_MS_n`.
  - Any state→IDLE when `enable`=0; this overrides all other transitions.
- **Timebase:**
  - A prescaler counts 0..`TICK_CYCLES`-1 and emits a tick on wrap.
  - A 16-bit ms counter increments on each tick.
  - Both counters clear on every state entry.
- **LFSR:**
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle regardless of `enable`; reloads `LFSR_SEED` only on reset.
  - Free-running so that player timing randomises the sequence.
- **Mole select:**
  - On GAP→UP, candidate = `lfsr[2:0]`.
  - If candidate equals the current `mole_index`, use candidate+1 mod 8, so there are no back-to-back repeats.
  - The result is latched into `mole_index`.
- **Difficulty:** latched into an internal register on GAP→UP; changes during UP have no effect until the next mole.
- **Hit detection:**
  - A registered copy of `btn_hit` yields per-bit rising edges.
  - A correct hit is a rising edge on `btn_hit[mole_index]` while in UP.
  - Rising edges on any other bit, held levels, and presses in GAP or IDLE are ignored.
- **Simultaneous events:**
  - A correct hit in the same cycle as up-window expiry counts as a hit; `timeout_pulse` is suppressed.
  - `enable` falling in that cycle suppresses both pulses.
- **Reset values:** `mole_leds`=0, `mole_index`=0, `hit_pulse`=0, `timeout_pulse`=0, state IDLE, counters 0, edge registers 0, LFSR=`LFSR_SEED`, difficulty register 0.

## Timing
- All outputs are registered.
- `mole_leds` = one-hot of `mole_index` while in UP, else 0.
  - Goes nonzero the cycle after the GAP→UP decision.
  - Clears the cycle after the hit or expiry decision.
- **`hit_pulse` latency:**
  - High for exactly one cycle.
  - Asserted 2 cycles after the `btn_hit` rising edge at the input (edge register plus output register).
  - Coincident with `mole_leds` clearing.
- **`timeout_pulse`:**
  - High for exactly one cycle.
  - Asserted on the cycle `mole_leds` clears after UP lasted `UP_MS_n`×`TICK_CYCLES` cycles (±1).
- **Enable:**
  - The cycle after `enable` falls, `mole_leds`=0 and both pulses are 0; nothing is pending on re-enable.
  - On re-enable, the first mole appears `GAP_MS`×`TICK_CYCLES` (+2) cycles after `enable` rises.
- **Asynchronous reset mid-UP:** outputs go to reset values immediately; no pulse is emitted.
- At most one of `hit_pulse` / `timeout_pulse` is high in any cycle; at most one pulse per mole.

## Test plan
All scenarios use `TICK_CYCLES`=4, `GAP_MS`=3, `UP_MS_0..3`=8/6/4/2.
- **Hit:** enable=1, difficulty 0; wait for `mole_leds`≠0; press `btn_hit[mole_index]` for 3 cycles → exactly one `hit_pulse` 2 cycles after the press, `mole_leds`=0 the same cycle, next mole after 12 (+2) cycles.
- **Timeout and no repeat:** difficulty 3, no presses → `mole_leds` lit for 8 (±1) cycles, one `timeout_pulse` each mole; over 50 moles, no two consecutive `mole_index` values are equal.
- **Wrong and held buttons:**
  - Press a wrong button → no pulse; mole still times out.
  - Hold the correct button from before UP → no `hit_pulse`; release and re-press → `hit_pulse`.
- **Simultaneous hit and expiry:** press the correct button so its edge lands on the expiry cycle → `hit_pulse`=1, `timeout_pulse` never asserted for that mole.
- **Difficulty latch:** change `difficulty_level` 0→3 mid-UP → current mole still lasts 32 cycles; next mole lasts 8 cycles.
- **Disable and reset mid-UP:**
  - Drop `enable` mid-UP → next cycle `mole_leds`=0, no pulses.
  - Assert `rst_n`=0 mid-UP → immediate reset values; after release, LFSR restarts from `LFSR_SEED` and the mole sequence repeats identically.

Source files
------------

// File: rtl/mole_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mole_controller
// Description : Whack-a-mole round engine. Lights one pseudo-random mole per
//               round and judges button presses, emitting hit/timeout strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module mole_controller #(
    parameter int          TICK_CYCLES = 100000,
    parameter int          GAP_MS      = 250,
    parameter int          UP_MS_0     = 1500,
    parameter int          UP_MS_1     = 1000,
    parameter int          UP_MS_2     = 700,
    parameter int          UP_MS_3     = 450,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] difficulty_level,
    input  logic [7:0] btn_hit,
    output logic [7:0] mole_leds,
    output logic [2:0] mole_index,
    output logic       hit_pulse,
    output logic       timeout_pulse
);

    localparam int                   c_presc_w   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_CYCLES - 1);
    localparam logic [15:0]          c_gap_ms    = 16'(GAP_MS);
    localparam logic [15:0]          c_up_ms_0   = 16'(UP_MS_0);
    localparam logic [15:0]          c_up_ms_1   = 16'(UP_MS_1);
    localparam logic [15:0]          c_up_ms_2   = 16'(UP_MS_2);
    localparam logic [15:0]          c_up_ms_3   = 16'(UP_MS_3);
    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0]          c_lfsr_taps = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_UP   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_presc_w-1:0]   r_presc;
    logic [15:0]            r_ms;
    logic [15:0]            r_lfsr;
    logic [15:0]            w_lfsr_next;
    logic [7:0]             r_btn_prev;
    logic [7:0]             r_btn_rise;
    logic [2:0]             r_mole_index;
    logic [1:0]             r_diff;
    logic [7:0]             r_mole_leds;
    logic                   r_hit_pulse;
    logic                   r_timeout_pulse;

    logic                   w_tick;
    logic                   w_restart;
    logic [15:0]            w_up_ms;
    logic                   w_hit;
    logic                   w_expire;
    logic                   w_gap_done;
    logic [2:0]             w_cand;
    logic [2:0]             w_mole_sel;
    logic [2:0]             w_mole_next;
    logic [7:0]             w_leds_next;
    logic                   w_load_mole;
    logic                   w_hit_evt;
    logic                   w_timeout_evt;

    assign w_tick      = (r_presc == c_presc_max);
    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_taps) : (r_lfsr >> 1);

    always_comb begin
        case (r_diff)
            2'd0:    w_up_ms = c_up_ms_0;
            2'd1:    w_up_ms = c_up_ms_1;
            2'd2:    w_up_ms = c_up_ms_2;
            default: w_up_ms = c_up_ms_3;
        endcase
    end

    assign w_hit      = (r_state == S_UP) && r_btn_rise[r_mole_index];
    assign w_expire   = (r_state == S_UP) && (r_ms == w_up_ms);
    assign w_gap_done = (r_state == S_GAP) && (r_ms == c_gap_ms);

    // Bump a repeated candidate so the same mole never comes up twice in a row
    assign w_cand     = r_lfsr[2:0];
    assign w_mole_sel = (w_cand == r_mole_index) ? (w_cand + 3'd1) : w_cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_mole   = 1'b0;
        w_hit_evt     = 1'b0;
        w_timeout_evt = 1'b0;
        if (!enable) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_GAP;
                S_GAP: begin
                    if (w_gap_done) begin
                        w_state_next = S_UP;
                        w_load_mole  = 1'b1;
                    end
                end
                S_UP: begin
                    if (w_hit) begin
                        w_state_next = S_GAP;
                        w_hit_evt    = 1'b1;
                    end else if (w_expire) begin
                        w_state_next  = S_GAP;
                        w_timeout_evt = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
        w_mole_next = w_load_mole ? w_mole_sel : r_mole_index;
        w_leds_next = (w_state_next == S_UP) ? (8'd1 << w_mole_next) : 8'd0;
    end

    // Timebase restarts on every state entry and stays parked while idle
    assign w_restart = (w_state_next != r_state) || (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (w_restart) begin
            r_presc <= '0;
            r_ms    <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_ms    <= r_ms + 16'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= LFSR_SEED;
            r_btn_prev <= '0;
            r_btn_rise <= '0;
        end else begin
            r_lfsr     <= w_lfsr_next;
            r_btn_prev <= btn_hit;
            r_btn_rise <= btn_hit & ~r_btn_prev;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mole_index    <= '0;
            r_diff          <= '0;
            r_mole_leds     <= '0;
            r_hit_pulse     <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_mole_index    <= w_mole_next;
            if (w_load_mole) begin
                r_diff <= difficulty_level;
            end
            r_mole_leds     <= w_leds_next;
            r_hit_pulse     <= w_hit_evt;
            r_timeout_pulse <= w_timeout_evt;
        end
    end

    assign mole_leds     = r_mole_leds;
    assign mole_index    = r_mole_index;
    assign hit_pulse     = r_hit_pulse;
    assign timeout_pulse = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_mole_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mole_controller
// Description : Scoreboard bench for mole_controller with an LFSR mole model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mole_controller;

    localparam int c_ev_hit = 1;
    localparam int c_ev_to  = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] difficulty_level = 2'd0;
    logic [7:0] btn_hit = 8'd0;
    logic [7:0] mole_leds;
    logic [2:0] mole_index;
    logic       hit_pulse;
    logic       timeout_pulse;

    mole_controller #(
        .TICK_CYCLES (4),
        .GAP_MS      (3),
        .UP_MS_0     (8),
        .UP_MS_1     (6),
        .UP_MS_2     (4),
        .UP_MS_3     (2),
        .LFSR_SEED   (16'hACE1)
    ) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .difficulty_level (difficulty_level),
        .btn_hit          (btn_hit),
        .mole_leds        (mole_leds),
        .mole_index       (mole_index),
        .hit_pulse        (hit_pulse),
        .timeout_pulse    (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int sb_q[$];
    int seq_all[8];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference LFSR; m_lfsr_d holds the value seen during the previous cycle
    logic [15:0] m_lfsr;
    logic [15:0] m_lfsr_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr   <= 16'hACE1;
            m_lfsr_d <= 16'hACE1;
        end else begin
            m_lfsr   <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            m_lfsr_d <= m_lfsr;
        end
    end

    logic [7:0] m_prev_leds = 8'd0;
    int         m_idx = 0;

    always begin
        int kind;
        int cand;
        int exp_idx;
        @(negedge clk);
        if (!rst_n) begin
            m_prev_leds = 8'd0;
            m_idx       = 0;
        end else begin
            check("pulse_excl", int'(hit_pulse & timeout_pulse), 0);
            if (hit_pulse || timeout_pulse) begin
                kind = hit_pulse ? c_ev_hit : c_ev_to;
                if (sb_q.size() == 0) check("unexpected_pulse", kind, 0);
                else                  check("pulse_kind", kind, sb_q.pop_front());
            end
            if (m_prev_leds == 8'd0 && mole_leds != 8'd0) begin
                cand    = int'(m_lfsr_d[2:0]);
                exp_idx = (cand == m_idx) ? ((cand + 1) % 8) : cand;
                check("mole_index", int'(mole_index), exp_idx);
                m_idx = exp_idx;
            end
            if (mole_leds != 8'd0) check("leds_onehot", int'(mole_leds), 1 << m_idx);
            m_prev_leds = mole_leds;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mole(output int idx, output int n);
        n   = 0;
        idx = 0;
        while (mole_leds == 8'd0 && n < 100) begin
            tick();
            n++;
        end
        if (mole_leds == 8'd0) check("mole_appear", 0, 1);
        for (int i = 0; i < 8; i++) if (mole_leds[i]) idx = i;
    endtask

    task automatic wait_off(output int n);
        n = 0;
        while (mole_leds != 8'd0 && n < 60) begin
            tick();
            n++;
        end
        if (mole_leds != 8'd0) check("mole_clear", 0, 1);
    endtask

    task automatic stop_game();
        enable = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_seq(input int base);
        int idx;
        int n;
        rst_n = 1'b0;
        #2;
        check("rst_leds", int'(mole_leds), 0);
        check("rst_index", int'(mole_index), 0);
        check("rst_pulses", int'(hit_pulse | timeout_pulse), 0);
        repeat (3) tick();
        rst_n            = 1'b1;
        difficulty_level = 2'd3;
        enable           = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_mole(idx, n);
            seq_all[base + k] = idx;
            sb_q.push_back(c_ev_to);
            wait_off(n);
        end
        stop_game();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int idx;
        int n;
        int prev;

        tick();
        check("reset_leds", int'(mole_leds), 0);
        check("reset_index", int'(mole_index), 0);
        check("reset_hit", int'(hit_pulse), 0);
        check("reset_timeout", int'(timeout_pulse), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Correct hit
        difficulty_level = 2'd0;
        enable = 1'b1;
        wait_mole(idx, n);
        check("first_mole_lat", int'(n >= 12 && n <= 14), 1);
        btn_hit = 8'd1 << idx;
        sb_q.push_back(c_ev_hit);
        tick();
        check("hit_early", int'(hit_pulse), 0);
        tick();
        check("hit_pulse", int'(hit_pulse), 1);
        check("hit_leds_clear", int'(mole_leds), 0);
        tick();
        check("hit_once", int'(hit_pulse), 0);
        btn_hit = 8'd0;
        wait_mole(idx, n);
        check("regap_lat", int'(n + 1 >= 12 && n + 1 <= 14), 1);
        stop_game();

        // Timeouts at difficulty 3 and no back-to-back repeats
        difficulty_level = 2'd3;
        enable = 1'b1;
        prev = -1;
        for (int k = 0; k < 50; k++) begin
            wait_mole(idx, n);
            sb_q.push_back(c_ev_to);
            if (k > 0) check("no_repeat", int'(idx != prev), 1);
            prev = idx;
            wait_off(n);
            check("lit_d3", int'(n >= 7 && n <= 9), 1);
            check("timeout_pulse", int'(timeout_pulse), 1);
        end
        stop_game();

        // Wrong button, then held-through-entry button
        enable = 1'b1;
        wait_mole(idx, n);
        sb_q.push_back(c_ev_to);
        btn_hit = 8'd1 << ((idx + 1) % 8);
        tick();
        tick();
        btn_hit = 8'd0;
        wait_off(n);
        check("wrong_btn_to", int'(timeout_pulse), 1);
        btn_hit = 8'hFF;
        difficulty_level = 2'd0;
        wait_mole(idx, n);
        tick();
        tick();
        check("held_no_hit", int'(hit_pulse), 0);
        check("held_leds_on", int'(mole_leds != 8'd0), 1);
        btn_hit = 8'd0;
        tick();
        btn_hit = 8'd1 << idx;
        sb_q.push_back(c_ev_hit);
        tick();
        tick();
        check("repress_hit", int'(hit_pulse), 1);
        btn_hit = 8'd0;
        stop_game();

        // Hit edge on the expiry cycle
        difficulty_level = 2'd3;
        enable = 1'b1;
        wait_mole(idx, n);
        repeat (7) tick();
        btn_hit = 8'd1 << idx;
        sb_q.push_back(c_ev_hit);
        tick();
        check("sim_pre", int'(hit_pulse | timeout_pulse), 0);
        tick();
        check("sim_hit", int'(hit_pulse), 1);
        check("sim_no_to", int'(timeout_pulse), 0);
        check("sim_leds", int'(mole_leds), 0);
        btn_hit = 8'd0;
        tick();
        tick();
        stop_game();

        // Difficulty latched at mole entry
        difficulty_level = 2'd0;
        enable = 1'b1;
        wait_mole(idx, n);
        sb_q.push_back(c_ev_to);
        n = 0;
        while (mole_leds != 8'd0 && n < 60) begin
            if (n == 5) difficulty_level = 2'd3;
            tick();
            n++;
        end
        check("latched_d0", int'(n >= 31 && n <= 33), 1);
        check("latched_to", int'(timeout_pulse), 1);
        wait_mole(idx, n);
        sb_q.push_back(c_ev_to);
        wait_off(n);
        check("next_d3", int'(n >= 7 && n <= 9), 1);
        stop_game();

        // Disable mid-UP, then re-enable
        difficulty_level = 2'd0;
        enable = 1'b1;
        wait_mole(idx, n);
        repeat (5) tick();
        enable = 1'b0;
        tick();
        check("dis_leds", int'(mole_leds), 0);
        check("dis_pulses", int'(hit_pulse | timeout_pulse), 0);
        tick();
        check("dis_pulses2", int'(hit_pulse | timeout_pulse), 0);
        enable = 1'b1;
        wait_mole(idx, n);
        check("reenable_lat", int'(n >= 12 && n <= 14), 1);
        repeat (3) tick();

        // Reset mid-UP, then confirm the sequence replays
        run_seq(0);
        run_seq(4);
        for (int k = 0; k < 4; k++) check("seq_repeat", seq_all[4 + k], seq_all[k]);

        repeat (4) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
